// File: rtl/alarm_game_ctrl.sv
// Alarm controller: rings on the rising edge of a time match, supports snooze,
// and gates dismissal behind an N-round switch-matching game.
module alarm_game_ctrl #(
  parameter int N_SW       = 10,
  parameter int ROUNDS     = 3,
  parameter int TIME_W     = 16,
  parameter int LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hB9,
  parameter int ROUND_TO   = 1000,
  parameter int SNOOZE_CYC = 5000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic [TIME_W-1:0]            current_time,
  input  logic [TIME_W-1:0]            alarm_time,
  input  logic                         dismiss,
  input  logic                         snooze,
  input  logic [N_SW-1:0]              sw,
  output logic [2:0]                   state,
  output logic                         ringing,
  output logic [N_SW-1:0]              target_led,
  output logic [$clog2(ROUNDS+1)-1:0]  round_cnt,
  output logic                         done,
  output logic                         fail
);

  localparam int IW   = (N_SW > 1) ? $clog2(N_SW) : 1;
  localparam int RW   = $clog2(ROUNDS + 1);
  localparam int TMAX = (ROUND_TO > SNOOZE_CYC) ? ROUND_TO : SNOOZE_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RING  = 3'd2,
    S_GAME  = 3'd3,
    S_SNZ   = 3'd4
  } st_t;

  st_t               st;
  logic [LFSR_W-1:0] lfsr;
  logic              hit_d;
  logic              armed;
  logic [TW-1:0]     tmr;
  logic [IW-1:0]     tgt_idx;

  logic              fb;
  logic              hit;
  logic              trig;
  logic [IW-1:0]     raw;
  logic [IW-1:0]     nidx;
  logic [N_SW-1:0]   ntgt;
  logic              pass;
  logic              wrong;
  logic              tout;
  logic              snz_end;
  logic              last;

  assign state = st;

  assign fb   = lfsr[LFSR_W-1] ^ lfsr[LFSR_W-3];
  assign hit  = (current_time == alarm_time);
  assign trig = hit & ~hit_d;

  // Never repeat the previous target index back-to-back.
  assign raw  = IW'(lfsr % LFSR_W'(N_SW));
  assign nidx = (raw != tgt_idx) ? raw :
                (raw == IW'(N_SW - 1)) ? '0 : raw + IW'(1);
  assign ntgt = {{(N_SW-1){1'b0}}, 1'b1} << nidx;

  assign pass    = armed && (sw == target_led);
  assign wrong   = armed && (sw != '0) && !pass;
  assign tout    = (tmr == TW'(ROUND_TO - 1));
  assign snz_end = (tmr == TW'(SNOOZE_CYC - 1));
  assign last    = (round_cnt == RW'(ROUNDS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st         <= S_IDLE;
      lfsr       <= LFSR_SEED;
      hit_d      <= 1'b0;
      armed      <= 1'b0;
      tmr        <= '0;
      tgt_idx    <= '0;
      ringing    <= 1'b0;
      target_led <= '0;
      round_cnt  <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      lfsr  <= {lfsr[LFSR_W-2:0], fb};
      hit_d <= hit;
      done  <= 1'b0;
      fail  <= 1'b0;
      if (!enable) begin
        st         <= S_IDLE;
        armed      <= 1'b0;
        tmr        <= '0;
        tgt_idx    <= '0;
        ringing    <= 1'b0;
        target_led <= '0;
        round_cnt  <= '0;
      end else begin
        unique case (st)
          S_IDLE: begin
            st <= S_ARMED;
          end
          S_ARMED: begin
            if (trig) begin
              st      <= S_RING;
              ringing <= 1'b1;
            end
          end
          S_RING, S_SNZ: begin
            if (dismiss) begin
              st         <= S_GAME;
              ringing    <= 1'b0;
              round_cnt  <= '0;
              tmr        <= '0;
              armed      <= 1'b0;
              tgt_idx    <= nidx;
              target_led <= ntgt;
            end else if (st == S_RING) begin
              if (snooze) begin
                st      <= S_SNZ;
                ringing <= 1'b0;
                tmr     <= '0;
              end
            end else if (snz_end) begin
              st      <= S_RING;
              ringing <= 1'b1;
              tmr     <= '0;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          S_GAME: begin
            if (pass) begin
              tmr   <= '0;
              armed <= 1'b0;
              if (last) begin
                st         <= S_ARMED;
                done       <= 1'b1;
                round_cnt  <= '0;
                target_led <= '0;
              end else begin
                round_cnt  <= round_cnt + RW'(1);
                tgt_idx    <= nidx;
                target_led <= ntgt;
              end
            end else if (wrong || tout) begin
              fail       <= 1'b1;
              round_cnt  <= '0;
              tmr        <= '0;
              armed      <= 1'b0;
              tgt_idx    <= nidx;
              target_led <= ntgt;
            end else begin
              tmr <= tmr + TW'(1);
              if (sw == '0) armed <= 1'b1;
            end
          end
          default: begin
            st         <= S_IDLE;
            ringing    <= 1'b0;
            target_led <= '0;
            round_cnt  <= '0;
            tmr        <= '0;
            armed      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
